// File: rtl/s2mb_pkg.sv
// Shared FSM state type and mailbox layout constants for the s2 mailbox reader.
package s2mb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SEQ,
    S_WAIT_SEQ,
    S_RD_PAT,
    S_WAIT_PAT,
    S_RD_PER,
    S_WAIT_PER,
    S_APPLY,
    S_WR_ACK
  } s2mb_state_e;

  localparam logic [1:0] MB_SEQ = 2'd0;
  localparam logic [1:0] MB_PAT = 2'd1;
  localparam logic [1:0] MB_PER = 2'd2;
  localparam logic [1:0] MB_ACK = 2'd3;

  localparam logic [3:0] BE_ALL = 4'hF;

  // SEQ of zero means "mailbox never written"; a repeat of the last SEQ means "nothing new".
  function automatic logic seq_is_new(input logic [31:0] seq, input logic [31:0] last_seq);
    return (seq != 32'h0) && (seq != last_seq);
  endfunction

endpackage

// File: rtl/s2mb_blinker.sv
// Blink time base: divides clk by TICK_CYCLES and toggles a phase every `period` ticks.
// Only instantiated when S2MB_BLINK_EN is defined.
module s2mb_blinker #(
  parameter int TICK_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic [15:0] period,
  output logic        led_on
);

  localparam int                TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic [15:0]       period_q;
  logic [15:0]       phase_cnt;
  logic              phase_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      period_q  <= '0;
      phase_cnt <= '0;
      phase_on  <= 1'b0;
    end else if (restart) begin
      period_q  <= period;
      tick_cnt  <= TICK_LAST;
      phase_cnt <= period - 16'd1;
      phase_on  <= 1'b1;
    end else if (tick_cnt == '0) begin
      tick_cnt <= TICK_LAST;
      if (phase_cnt == '0) begin
        phase_cnt <= period_q - 16'd1;
        phase_on  <= ~phase_on;
      end else begin
        phase_cnt <= phase_cnt - 16'd1;
      end
    end else begin
      tick_cnt <= tick_cnt - TICK_W'(1);
    end
  end

  // A zero period means steady on; the phase keeps running but is ignored.
  assign led_on = (period_q == '0) || phase_on;

endmodule

// File: rtl/s2_mailbox_reader.sv
// Polls the HPS command mailbox on the on-chip RAM s2 port, applies commands to the LEDs and acks them.
// Optional blinking of the LED pattern is enabled with the S2MB_BLINK_EN macro.
//
//  state      | meaning
//  S_IDLE     | poll timer running, no bus activity
//  S_RD_SEQ   | read strobe for mailbox SEQ word
//  S_WAIT_SEQ | wait for SEQ data; drop back to IDLE if nothing new
//  S_RD_PAT   | read strobe for PATTERN word
//  S_WAIT_PAT | wait for PATTERN data
//  S_RD_PER   | read strobe for PERIOD word
//  S_WAIT_PER | wait for PERIOD data
//  S_APPLY    | commit pattern/period, record SEQ, bump cmd_count
//  S_WR_ACK   | write strobe of SEQ into the ACK word
module s2_mailbox_reader
  import s2mb_pkg::*;
#(
  parameter int                ADDR_W       = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                READ_LATENCY = 1,
  parameter int                POLL_CYCLES  = 50000,
  parameter int                TICK_CYCLES  = 50000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] s2_address,
  output logic              s2_chipselect,
  output logic              s2_write,
  output logic [31:0]       s2_writedata,
  output logic [3:0]        s2_byteenable,
  output logic              s2_clken,
  input  logic [31:0]       s2_readdata,
  output logic [7:0]        led_out,
  output logic [15:0]       cmd_count,
  output logic              busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > 2 || POLL_CYCLES < 1 || TICK_CYCLES < 1) begin : g_param_check
    $error("s2_mailbox_reader: illegal parameter value");
  end

  localparam int                POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);

  localparam logic [ADDR_W-1:0] ADDR_SEQ = BASE_ADDR + ADDR_W'(MB_SEQ);
  localparam logic [ADDR_W-1:0] ADDR_PAT = BASE_ADDR + ADDR_W'(MB_PAT);
  localparam logic [ADDR_W-1:0] ADDR_PER = BASE_ADDR + ADDR_W'(MB_PER);
  localparam logic [ADDR_W-1:0] ADDR_ACK = BASE_ADDR + ADDR_W'(MB_ACK);

  s2mb_state_e       state;
  logic [POLL_W-1:0] poll_cnt;
  logic              wait_cnt;
  logic              wait_last;
  logic [31:0]       last_seq;
  logic [31:0]       seq_pend;
  logic [7:0]        pat_pend;
  logic [7:0]        pat_q;
`ifdef S2MB_BLINK_EN
  logic [15:0]       per_pend;
`endif

  // readdata is only trusted on the final wait cycle of each read.
  assign wait_last = (wait_cnt == 1'(READ_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      poll_cnt      <= '0;
      wait_cnt      <= 1'b0;
      s2_address    <= '0;
      s2_chipselect <= 1'b0;
      s2_write      <= 1'b0;
      s2_writedata  <= '0;
      last_seq      <= '0;
      seq_pend      <= '0;
      pat_pend      <= '0;
      pat_q         <= '0;
      cmd_count     <= '0;
`ifdef S2MB_BLINK_EN
      per_pend      <= '0;
`endif
    end else begin
      s2_chipselect <= 1'b0;
      s2_write      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (poll_cnt == POLL_LAST) begin
            poll_cnt      <= '0;
            state         <= S_RD_SEQ;
            s2_chipselect <= 1'b1;
            s2_address    <= ADDR_SEQ;
          end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
          end
        end
        S_RD_SEQ: begin
          wait_cnt <= 1'b0;
          state    <= S_WAIT_SEQ;
        end
        S_WAIT_SEQ: begin
          if (!wait_last) begin
            wait_cnt <= 1'b1;
          end else if (seq_is_new(s2_readdata, last_seq)) begin
            seq_pend      <= s2_readdata;
            state         <= S_RD_PAT;
            s2_chipselect <= 1'b1;
            s2_address    <= ADDR_PAT;
          end else begin
            poll_cnt <= '0;
            state    <= S_IDLE;
          end
        end
        S_RD_PAT: begin
          wait_cnt <= 1'b0;
          state    <= S_WAIT_PAT;
        end
        S_WAIT_PAT: begin
          if (!wait_last) begin
            wait_cnt <= 1'b1;
          end else begin
            pat_pend      <= s2_readdata[7:0];
            state         <= S_RD_PER;
            s2_chipselect <= 1'b1;
            s2_address    <= ADDR_PER;
          end
        end
        S_RD_PER: begin
          wait_cnt <= 1'b0;
          state    <= S_WAIT_PER;
        end
        S_WAIT_PER: begin
          if (!wait_last) begin
            wait_cnt <= 1'b1;
          end else begin
`ifdef S2MB_BLINK_EN
            per_pend <= s2_readdata[15:0];
`endif
            state <= S_APPLY;
          end
        end
        S_APPLY: begin
          pat_q         <= pat_pend;
          last_seq      <= seq_pend;
          cmd_count     <= cmd_count + 16'd1;
          state         <= S_WR_ACK;
          s2_chipselect <= 1'b1;
          s2_write      <= 1'b1;
          s2_address    <= ADDR_ACK;
          s2_writedata  <= seq_pend;
        end
        S_WR_ACK: begin
          poll_cnt <= '0;
          state    <= S_IDLE;
        end
        default: begin
          poll_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef S2MB_BLINK_EN
  logic blink_on;

  // Period is handed over at APPLY so the blink phase restarts with the LEDs on.
  s2mb_blinker #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_blinker (
    .clk    (clk),
    .reset  (reset),
    .restart(state == S_APPLY),
    .period (per_pend),
    .led_on (blink_on)
  );

  assign led_out = blink_on ? pat_q : 8'h00;
`else
  assign led_out = pat_q;
`endif

  assign busy          = (state != S_IDLE);
  assign s2_byteenable = BE_ALL;
  assign s2_clken      = 1'b1;

endmodule
